// File: rtl/quant_mul_stream_if.sv
// Stream/config bundle for quant_mul_stream. The master side is the upstream
// load buffer plus downstream writeback; the slave side is the MUL unit.
interface quant_mul_stream_if #(
  parameter int NUM_LANES = 8,
  parameter int LEN_W     = 16
);
  logic                   cfg_load;
  logic [LEN_W-1:0]       cfg_len;
  logic                   cfg_bcast;
  logic signed [31:0]     cfg_in1_off;
  logic signed [31:0]     cfg_in2_off;
  logic signed [31:0]     cfg_out_mult;
  logic signed [31:0]     cfg_out_shift;
  logic signed [31:0]     cfg_out_off;
  logic signed [31:0]     cfg_act_min;
  logic signed [31:0]     cfg_act_max;
  logic                   valid_in;
  logic                   ready_o;
  logic [8*NUM_LANES-1:0] input1;
  logic [8*NUM_LANES-1:0] input2;
  logic                   valid_o;
  logic                   ready_in;
  logic [8*NUM_LANES-1:0] data_o;
  logic                   last_o;
  logic                   busy_o;

  modport master (
    output cfg_load, cfg_len, cfg_bcast, cfg_in1_off, cfg_in2_off, cfg_out_mult,
           cfg_out_shift, cfg_out_off, cfg_act_min, cfg_act_max,
           valid_in, input1, input2, ready_in,
    input  ready_o, valid_o, data_o, last_o, busy_o
  );

  modport slave (
    input  cfg_load, cfg_len, cfg_bcast, cfg_in1_off, cfg_in2_off, cfg_out_mult,
           cfg_out_shift, cfg_out_off, cfg_act_min, cfg_act_max,
           valid_in, input1, input2, ready_in,
    output ready_o, valid_o, data_o, last_o, busy_o
  );
endinterface

// File: rtl/quant_mul_stream.sv
// Quantized int8 elementwise multiply over NUM_LANES lanes with requantization,
// activation clamp, frame sequencing and a 4-stage globally-stalled pipeline.

// One lane of the datapath: offset add, multiply, scale, round/offset/clamp.
module quant_mul_lane (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic signed [7:0] in1_i,
  input  logic signed [7:0] in2_i,
  input  logic signed [31:0] in1_off_i,
  input  logic signed [31:0] in2_off_i,
  input  logic signed [31:0] mult_i,
  input  logic signed [31:0] shift_i,
  input  logic signed [31:0] out_off_i,
  input  logic signed [31:0] act_min_i,
  input  logic signed [31:0] act_max_i,
  output logic [7:0]        res_o
);
  localparam logic signed [31:0] INT_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT_MAX = 32'sh7fff_ffff;

  logic signed [31:0] a_q, a_d, b_q, b_d, p_q, p_d, y_q, y_d;
  logic [7:0]         r_q, r_d;
  logic signed [31:0] xs;
  logic signed [63:0] xs64, m64, rnd;
  logic [4:0]         e;
  logic signed [31:0] mask, rem, thr, q_rd;
  logic signed [32:0] o;

  // S1: sign-extend inputs and add zero-point offsets
  always_comb begin
    a_d = $signed({{24{in1_i[7]}}, in1_i}) + in1_off_i;
    b_d = $signed({{24{in2_i[7]}}, in2_i}) + in2_off_i;
  end

  // S2: raw product, wrapped to 32 bits
  always_comb begin
    p_d = a_q * b_q;
  end

  // S3: optional left shift, then saturating rounding doubling high multiply
  always_comb begin
    xs   = (shift_i > 0) ? (p_q <<< shift_i) : p_q;
    xs64 = xs;
    m64  = mult_i;
    rnd  = (xs64 * m64 + 64'sd1073741824) >>> 31;
    if (xs == INT_MIN && mult_i == INT_MIN) y_d = INT_MAX;
    else                                    y_d = 32'(rnd);
  end

  // S4: rounding right shift (half away from zero), output offset, clamps
  always_comb begin
    if (shift_i >= 0)            e = 5'd0;
    else if (shift_i < -32'sd31) e = 5'd31;
    else                         e = 5'(-shift_i);
    mask = (32'sd1 <<< e) - 32'sd1;
    rem  = y_q & mask;
    thr  = (mask >>> 1) + $signed({31'd0, y_q[31]});
    q_rd = (y_q >>> e) + $signed({31'd0, rem > thr});
    o    = $signed({q_rd[31], q_rd}) + $signed({out_off_i[31], out_off_i});
    if (o < $signed({act_min_i[31], act_min_i})) o = $signed({act_min_i[31], act_min_i});
    if (o > $signed({act_max_i[31], act_max_i})) o = $signed({act_max_i[31], act_max_i});
    if (o < -33'sd128) o = -33'sd128;
    if (o > 33'sd127)  o = 33'sd127;
    r_d = o[7:0];
  end

  // Stage registers, all advancing together on the global enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0; b_q <= '0; p_q <= '0; y_q <= '0; r_q <= '0;
    end else if (en_i) begin
      a_q <= a_d; b_q <= b_d; p_q <= p_d; y_q <= y_d; r_q <= r_d;
    end
  end

  assign res_o = r_q;
endmodule

module quant_mul_stream #(
  parameter int NUM_LANES = 8,
  parameter int LEN_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  quant_mul_stream_if.slave  bus
);
  localparam int STAGES = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic               bcast;
    logic signed [31:0] in1_off;
    logic signed [31:0] in2_off;
    logic signed [31:0] mult;
    logic signed [31:0] shift;
    logic signed [31:0] out_off;
    logic signed [31:0] act_min;
    logic signed [31:0] act_max;
  } cfg_t;

  state_t                     state_q, state_d;
  logic [LEN_W-1:0]           cnt_q, cnt_d;
  cfg_t                       cfg_q, cfg_d;
  logic                       cfg_we;
  logic [STAGES:1]            vld_pipe_q, last_pipe_q;
  logic                       stage_en, accept;
  logic [NUM_LANES-1:0][7:0]  res;

  // Whole pipeline stalls only when the output beat is held by downstream
  assign stage_en    = !vld_pipe_q[STAGES] || bus.ready_in;
  assign bus.ready_o = (state_q == RUN) && stage_en;
  assign accept      = bus.valid_in && bus.ready_o;

  assign cfg_d = '{bcast:   bus.cfg_bcast,
                   in1_off: bus.cfg_in1_off,
                   in2_off: bus.cfg_in2_off,
                   mult:    bus.cfg_out_mult,
                   shift:   bus.cfg_out_shift,
                   out_off: bus.cfg_out_off,
                   act_min: bus.cfg_act_min,
                   act_max: bus.cfg_act_max};

  // Frame sequencing: config latch in IDLE, beat countdown in RUN, wait for last out in DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_we  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.cfg_load) begin
        cfg_we  = 1'b1;
        cnt_d   = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
        state_d = RUN;
      end
      RUN: if (accept) begin
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: if (bus.valid_o && bus.ready_in && bus.last_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, beat counter and latched configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cfg_we) cfg_q <= cfg_d;
    end
  end

  // Valid and last tags shift alongside the lane data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else if (stage_en) begin
      vld_pipe_q  <= {vld_pipe_q[STAGES-1:1], accept};
      last_pipe_q <= {last_pipe_q[STAGES-1:1], accept && (cnt_q == LEN_W'(1))};
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    quant_mul_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .en_i      (stage_en),
      .in1_i     (bus.input1[8*i +: 8]),
      .in2_i     (cfg_q.bcast ? bus.input2[7:0] : bus.input2[8*i +: 8]),
      .in1_off_i (cfg_q.in1_off),
      .in2_off_i (cfg_q.in2_off),
      .mult_i    (cfg_q.mult),
      .shift_i   (cfg_q.shift),
      .out_off_i (cfg_q.out_off),
      .act_min_i (cfg_q.act_min),
      .act_max_i (cfg_q.act_max),
      .res_o     (res[i])
    );
  end

  assign bus.valid_o = vld_pipe_q[STAGES];
  assign bus.last_o  = last_pipe_q[STAGES];
  assign bus.data_o  = res;
  assign bus.busy_o  = (state_q != IDLE);
endmodule

// File: tb/tb_quant_mul_stream.sv
// Directed bench for quant_mul_stream: hand-computed vectors per scenario.
module tb_quant_mul_stream;
  logic clk = 1'b0;
  logic rst;
  int   vecs;
  int   errs;

  always #5 clk = ~clk;

  quant_mul_stream_if #(.NUM_LANES(8), .LEN_W(16)) bus ();

  quant_mul_stream #(.NUM_LANES(8), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] pk(input int l7, l6, l5, l4, l3, l2, l1, l0);
    return {8'(l7), 8'(l6), 8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // lane j of beat k carries k*16+j; used with the pass-through config
  function automatic logic [63:0] ramp(input int k);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(k*16 + j);
    return r;
  endfunction

  localparam logic [63:0] ONES = 64'h0101_0101_0101_0101;

  task automatic load_cfg(input int len, input logic bc, input int i1off, i2off,
                          mult, shift, ooff, amin, amax);
    bus.cfg_len = 16'(len);       bus.cfg_bcast = bc;
    bus.cfg_in1_off = i1off;      bus.cfg_in2_off = i2off;
    bus.cfg_out_mult = mult;      bus.cfg_out_shift = shift;
    bus.cfg_out_off = ooff;       bus.cfg_act_min = amin;
    bus.cfg_act_max = amax;
    bus.cfg_load = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
  endtask

  // pass-through: shift=1 and mult=2^30 make the scaling exactly x
  task automatic load_ident(input int len);
    load_cfg(len, 1'b0, 0, 0, 1073741824, 1, 0, -128, 127);
  endtask

  // Present one beat with ready_in=1, return result and cycles from accept edge
  task automatic send_beat(input logic [63:0] i1, i2, output logic [63:0] d,
                           output logic l, output int cyc);
    bus.input1 = i1; bus.input2 = i2; bus.valid_in = 1'b1; bus.ready_in = 1'b1;
    cyc = 0; d = '0; l = 1'b0;
    #1;
    while (!bus.ready_o && cyc < 20) begin @(negedge clk); #1; cyc++; end
    if (cyc >= 20) begin bus.valid_in = 1'b0; cyc = 99; return; end
    @(negedge clk);
    bus.valid_in = 1'b0;
    cyc = 1;
    while (!bus.valid_o && cyc < 20) begin @(negedge clk); cyc++; end
    d = bus.data_o; l = bus.last_o;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    vecs++; if (bus.valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b expected 0", bus.valid_o); end
    vecs++; if (bus.last_o !== 1'b0) begin errs++; $display("FAIL rst_last: got %b expected 0", bus.last_o); end
    vecs++; if (bus.data_o !== 64'h0) begin errs++; $display("FAIL rst_data: got %h expected 0", bus.data_o); end
    vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", bus.busy_o); end
    rst = 1'b1;
    @(negedge clk);
    vecs++; if (bus.ready_o !== 1'b0) begin errs++; $display("FAIL idle_ready: got %b expected 0", bus.ready_o); end
  endtask

  task automatic test_basic;
    logic [63:0] d; logic l; int cyc;
    load_cfg(1, 1'b0, 5, 128, 2071220384, -7, -71, -128, 127);
    send_beat(pk(-5,-4,-5,1,-7,-8,-10,-6), pk(0,1,0,4,-1,-2,-3,-1), d, l, cyc);
    vecs++; if (cyc !== 4) begin errs++; $display("FAIL basic_latency: got %0d expected 4", cyc); end
    vecs++; if (d !== pk(-71,-70,-71,-65,-73,-74,-76,-72)) begin errs++; $display("FAIL basic_data: got %h expected %h", d, pk(-71,-70,-71,-65,-73,-74,-76,-72)); end
    vecs++; if (l !== 1'b1) begin errs++; $display("FAIL basic_last: got %b expected 1", l); end
    vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL basic_idle: busy got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_bcast;
    logic [63:0] d; logic l; int cyc;
    load_cfg(1, 1'b1, 5, 128, 2071220384, -7, -71, -128, 127);
    send_beat(pk(-5,-4,-5,1,-7,-8,-10,-6), pk(9,33,-50,100,7,2,5,-1), d, l, cyc);
    vecs++; if (d !== pk(-71,-70,-71,-65,-73,-74,-76,-72)) begin errs++; $display("FAIL bcast_data: got %h expected %h", d, pk(-71,-70,-71,-65,-73,-74,-76,-72)); end
    vecs++; if (l !== 1'b1) begin errs++; $display("FAIL bcast_last: got %b expected 1", l); end
  endtask

  task automatic test_clamp;
    logic [63:0] d; logic l; int cyc;
    load_cfg(1, 1'b0, 5, 128, 2071220384, -7, -71, -75, -72);
    send_beat(pk(-5,-4,-5,1,-7,-8,-10,-6), pk(0,1,0,4,-1,-2,-3,-1), d, l, cyc);
    vecs++; if (d !== pk(-72,-72,-72,-72,-73,-74,-75,-72)) begin errs++; $display("FAIL clamp_data: got %h expected %h", d, pk(-72,-72,-72,-72,-73,-74,-75,-72)); end
  endtask

  // mult=2^30 halves (floor after +1), then shift=-1 rounds half away from zero
  task automatic test_round;
    logic [63:0] d; logic l; int cyc;
    load_cfg(1, 1'b0, 0, 0, 1073741824, -1, 0, -128, 127);
    send_beat(pk(127,0,-4,4,1,-2,-6,5), ONES, d, l, cyc);
    vecs++; if (d !== pk(32,0,-1,1,1,-1,-2,2)) begin errs++; $display("FAIL round_data: got %h expected %h", d, pk(32,0,-1,1,1,-1,-2,2)); end
  endtask

  // product == mult == INT32_MIN must saturate high, clamping to 127
  task automatic test_sat;
    logic [63:0] d; logic l; int cyc;
    load_cfg(1, 1'b0, 0, -2147483520, int'(32'h8000_0000), 0, 0, -128, 127);
    send_beat(pk(1,0,1,0,1,0,1,0), {8{8'h80}}, d, l, cyc);
    vecs++; if (d !== pk(127,0,127,0,127,0,127,0)) begin errs++; $display("FAIL sat_data: got %h expected %h", d, pk(127,0,127,0,127,0,127,0)); end
  endtask

  task automatic test_backpressure;
    int k, m, cyc;
    logic hs_in, hs_out, prev_stall, prev_l;
    logic [63:0] prev_d;
    load_ident(5);
    k = 0; m = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    bus.input2 = ONES;
    while (m < 5 && cyc < 200) begin
      bus.ready_in = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.valid_in = 1'b1;
      bus.input1   = ramp(k);
      #1;
      hs_in  = bus.ready_o;
      hs_out = bus.valid_o && bus.ready_in;
      if (prev_stall) begin
        vecs++;
        if (bus.valid_o !== 1'b1 || bus.data_o !== prev_d || bus.last_o !== prev_l) begin
          errs++; $display("FAIL bp_stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b", bus.valid_o, bus.data_o, bus.last_o, prev_d, prev_l);
        end
      end
      if (k >= 5) begin
        vecs++; if (bus.ready_o !== 1'b0) begin errs++; $display("FAIL bp_drain_ready: got %b expected 0", bus.ready_o); end
      end
      if (hs_out) begin
        vecs++;
        if (bus.data_o !== ramp(m) || bus.last_o !== (m == 4)) begin
          errs++; $display("FAIL bp_beat%0d: got d=%h l=%b expected d=%h l=%b", m, bus.data_o, bus.last_o, ramp(m), (m == 4));
        end
        m++;
      end
      prev_stall = bus.valid_o && !bus.ready_in;
      prev_d = bus.data_o; prev_l = bus.last_o;
      if (hs_in) k++;
      @(negedge clk);
      cyc++;
    end
    bus.valid_in = 1'b0; bus.ready_in = 1'b1;
    vecs++; if (m != 5) begin errs++; $display("FAIL bp_timeout: got %0d beats expected 5", m); end
    vecs++; if (k != 5) begin errs++; $display("FAIL bp_accepts: got %0d expected 5", k); end
    vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL bp_idle: busy got %b expected 0", bus.busy_o); end
    repeat (5) begin
      @(negedge clk);
      vecs++; if (bus.valid_o !== 1'b0) begin errs++; $display("FAIL bp_extra_beat: valid got %b expected 0", bus.valid_o); end
    end
  endtask

  task automatic test_cfg_guard;
    logic [63:0] d; logic l; int cyc;
    load_ident(2);
    send_beat(ramp(1), ONES, d, l, cyc);
    vecs++; if (d !== ramp(1) || l !== 1'b0) begin errs++; $display("FAIL guard_beat1: got d=%h l=%b expected d=%h l=0", d, l, ramp(1)); end
    bus.cfg_out_off = 10; bus.cfg_len = 16'd7; bus.cfg_out_mult = 0;
    bus.cfg_load = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
    send_beat(ramp(2), ONES, d, l, cyc);
    vecs++; if (d !== ramp(2)) begin errs++; $display("FAIL guard_data: got %h expected %h", d, ramp(2)); end
    vecs++; if (l !== 1'b1) begin errs++; $display("FAIL guard_last: got %b expected 1", l); end
    vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL guard_idle: busy got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_len_zero;
    logic [63:0] d; logic l; int cyc;
    load_ident(0);
    vecs++; if (bus.busy_o !== 1'b1) begin errs++; $display("FAIL len0_busy: got %b expected 1", bus.busy_o); end
    send_beat(ramp(3), ONES, d, l, cyc);
    vecs++; if (d !== ramp(3) || l !== 1'b1) begin errs++; $display("FAIL len0_beat: got d=%h l=%b expected d=%h l=1", d, l, ramp(3)); end
    vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL len0_idle: busy got %b expected 0", bus.busy_o); end
  endtask

  task automatic test_idle_valid;
    logic [63:0] d; logic l; int cyc;
    bus.valid_in = 1'b1; bus.input1 = ramp(7); bus.input2 = ONES; bus.ready_in = 1'b1;
    repeat (4) begin
      #1;
      vecs++; if (bus.ready_o !== 1'b0) begin errs++; $display("FAIL idle_vin_ready: got %b expected 0", bus.ready_o); end
      vecs++; if (bus.valid_o !== 1'b0) begin errs++; $display("FAIL idle_vin_valid: got %b expected 0", bus.valid_o); end
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    load_ident(1);
    send_beat(ramp(4), ONES, d, l, cyc);
    vecs++; if (d !== ramp(4) || l !== 1'b1) begin errs++; $display("FAIL idle_vin_next: got d=%h l=%b expected d=%h l=1", d, l, ramp(4)); end
  endtask

  task automatic test_reset_midframe;
    logic [63:0] d; logic l; int cyc;
    load_ident(5);
    bus.input2 = ONES; bus.ready_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.valid_in = 1'b1; bus.input1 = ramp(k);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    vecs++; if (bus.valid_o !== 1'b1) begin errs++; $display("FAIL mid_inflight: valid got %b expected 1", bus.valid_o); end
    #2 rst = 1'b0;
    #1;
    vecs++; if (bus.valid_o !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b expected 0", bus.valid_o); end
    vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy_o); end
    vecs++; if (bus.data_o !== 64'h0 || bus.last_o !== 1'b0) begin errs++; $display("FAIL mid_rst_data: got d=%h l=%b expected 0", bus.data_o, bus.last_o); end
    @(negedge clk);
    rst = 1'b1; bus.ready_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      vecs++; if (bus.valid_o !== 1'b0) begin errs++; $display("FAIL mid_stale_out: valid got %b expected 0", bus.valid_o); end
    end
    load_ident(1);
    send_beat(ramp(5), ONES, d, l, cyc);
    vecs++; if (cyc !== 4) begin errs++; $display("FAIL mid_new_latency: got %0d expected 4", cyc); end
    vecs++; if (d !== ramp(5) || l !== 1'b1) begin errs++; $display("FAIL mid_new_beat: got d=%h l=%b expected d=%h l=1", d, l, ramp(5)); end
    vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL mid_new_idle: busy got %b expected 0", bus.busy_o); end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst = 1'b0;
    bus.cfg_load = 1'b0; bus.cfg_len = '0; bus.cfg_bcast = 1'b0;
    bus.cfg_in1_off = '0; bus.cfg_in2_off = '0; bus.cfg_out_mult = '0;
    bus.cfg_out_shift = '0; bus.cfg_out_off = '0; bus.cfg_act_min = '0; bus.cfg_act_max = '0;
    bus.valid_in = 1'b0; bus.input1 = '0; bus.input2 = '0; bus.ready_in = 1'b1;
    test_reset;
    test_basic;
    test_bcast;
    test_clamp;
    test_round;
    test_sat;
    test_backpressure;
    test_cfg_guard;
    test_len_zero;
    test_idle_valid;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/quant_mul_stream.md
Name: quant_mul_stream

Overview:
- Parametrised successor to the fixed 8-lane quantized MUL unit.
- Performs TFLite-style int8 elementwise multiply over NUM_LANES lanes, with requantization to int8 and an activation clamp.
- Adds over the previous unit: ready/valid backpressure, frame-length sequencing with a last flag, a latched configuration, and a scalar-broadcast mode.
- Sits between the vector load buffer and the writeback path of the NPU datapath.

Parameters:
- NUM_LANES, 8, int8 lanes per beat.
- LEN_W, 16, width of the frame beat-count register.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- cfg_load  in  1  one-cycle pulse; latches all cfg_* inputs. Accepted only in IDLE.
- cfg_len  in  LEN_W  number of beats in the frame; 0 is treated as 1.
- cfg_bcast  in  1  1 = input2 lane 0 is broadcast to all lanes.
- cfg_in1_off  in  32  signed input1 offset.
- cfg_in2_off  in  32  signed input2 offset.
- cfg_out_mult  in  32  signed output multiplier.
- cfg_out_shift  in  32  signed output shift; positive = left.
- cfg_out_off  in  32  signed output offset.
- cfg_act_min  in  32  signed clamp minimum.
- cfg_act_max  in  32  signed clamp maximum.
- valid_in  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_in && ready_o.
- input1  in  8*NUM_LANES  lane i at bits [8i+7:8i], signed.
- input2  in  8*NUM_LANES  same lane packing as input1.
- valid_o  out  1  output beat valid.
- ready_in  in  1  downstream ready.
- data_o  out  8*NUM_LANES  int8 results, same lane packing as the inputs.
- last_o  out  1  asserted with the final beat of the frame.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all pipeline valids cleared; valid_o=0, last_o=0, data_o=0, busy_o=0; config registers cleared. Reset mid-frame discards all in-flight beats; no output is produced for them.
- States:
  - IDLE: cfg_load latches the config, loads beat_cnt=max(cfg_len,1), then goes to RUN. ready_o=0 in IDLE.
  - RUN: each accepted input beat decrements beat_cnt; when the beat with beat_cnt==1 is accepted, it is tagged last and state goes to DRAIN. ready_o=stage_en.
  - DRAIN: ready_o=0; when the output handshake of the tagged-last beat completes, state returns to IDLE.
- cfg_load in RUN or DRAIN is ignored; the latched config is unchanged.
- Pipeline: 4 stages, global enable stage_en = !valid_o || ready_in. Latency is exactly 4 cycles from input accept to valid_o when there is no stall. Throughput is 1 beat/cycle.
- Stall (valid_o && !ready_in): all stages hold; data_o and last_o are held stable.
- S1:
  - a_i = sext(input1_i) + in1_off.
  - b_i = sext(bcast ? input2_0 : input2_i) + in2_off.
- S2: p_i = a_i * b_i as signed 32-bit.
- S3:
  - If shift>0, p_i is left-shifted by shift.
  - Saturating rounding doubling high multiply by mult: (x*m + 2^30) >>> 31, computed in 64 bits.
  - Special case: x = m = INT32_MIN saturates to INT32_MAX.
- S4:
  - If shift<0, rounding divide by 2^(-shift). The remainder threshold is half, plus 1 when the value is negative (round half away from zero).
  - Add out_off.
  - Clamp to [act_min, act_max], then to [-128,127].
  - Truncate to 8 bits.
- last_o travels with its beat through the pipeline and is valid only when valid_o=1.
- valid_in is ignored unless ready_o=1. Beats presented in IDLE or DRAIN are not consumed.

Test Plan:
- Basic frame:
  - Config: cfg_len=1, in1_off=5, in2_off=128, mult=2071220384, shift=-7, out_off=-71, act_min=-128, act_max=127.
  - Stimulus (lanes 7..0): input1={-5,-4,-5,1,-7,-8,-10,-6}, input2={0,1,0,4,-1,-2,-3,-1}.
  - Required: data_o={-71,-70,-71,-65,-73,-74,-76,-72}, 4 cycles after accept, last_o=1, then IDLE.
- Broadcast:
  - Same config and input1, with cfg_bcast=1 and input2 lane0=-1.
  - Required: data_o={-71,-70,-71,-65,-73,-74,-76,-72}.
- Clamp:
  - Basic frame with act_max=-72, act_min=-75.
  - Required: {-72,-72,-72,-72,-73,-74,-75,-72}.
- Backpressure:
  - cfg_len=5, valid_in held high, ready_in toggling 1,0,0,1.
  - Required: no beat lost or duplicated; data_o stable during stalls; last_o only on beat 5; ready_o=0 in DRAIN.
- Config guard and length:
  - cfg_load pulsed mid-RUN is ignored.
  - cfg_len=0 behaves as 1 beat.
  - valid_in in IDLE is not consumed (ready_o=0).
- Reset mid-frame:
  - rst asserted with 3 beats in flight.
  - Required: valid_o=0 immediately; busy_o=0; after release, a new frame runs correctly.
